// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and default frame shape.
// Used by uart_tx and intended for reuse by a matching uart_rx.
package uart_pkg;

   // Frame phases. SYNC holds the line idle until the next bit-period strobe,
   // so every frame starts on a tick boundary.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SYNC   = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
      ST_PARITY = 3'd4,
      ST_STOP   = 3'd5
   } uart_state_t;

   // Default frame shape: 8 data bits, 1 stop bit.
   localparam int unsigned UART_DATA_BITS = 8;
   localparam int unsigned UART_STOP_BITS = 1;

   // Bit counter width, wide enough for up to 8 data bits.
   localparam int unsigned UART_BIT_CNT_W = 3;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: accepts one word per valid/ready handshake and serialises
// it as start bit, DATA_BITS data bits (LSB first), optional parity bit and
// STOP_BITS stop bits. Every bit lasts exactly one baud_tick period.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = UART_DATA_BITS,
   parameter bit          PARITY_EN  = 1'b0,
   parameter bit          PARITY_ODD = 1'b0,
   parameter int unsigned STOP_BITS  = UART_STOP_BITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 baud_tick,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 tx_busy
);

   localparam logic [UART_BIT_CNT_W-1:0] LAST_BIT  = UART_BIT_CNT_W'(DATA_BITS - 1);
   localparam logic                      LAST_STOP = 1'(STOP_BITS - 1);

   uart_state_t                state;
   uart_state_t                state_nxt;
   logic [DATA_BITS-1:0]       shreg;
   logic [DATA_BITS-1:0]       shreg_nxt;
   logic [UART_BIT_CNT_W-1:0]  bit_cnt;
   logic [UART_BIT_CNT_W-1:0]  bit_cnt_nxt;
   logic                       stop_cnt;
   logic                       stop_cnt_nxt;
   logic                       tx_nxt;
   logic                       ready_nxt;
   logic                       busy_nxt;
   logic                       parity;
   logic [DATA_BITS-1:0]       shreg_rot;

   // The shift register rotates rather than shifts, so after the last data
   // bit it holds the original word again; parity is insensitive to rotation
   // and can be taken from the register at any point in the frame.
   assign shreg_rot = {shreg[0], shreg[DATA_BITS-1:1]};
   assign parity    = (^shreg) ^ PARITY_ODD;

   // State, counters, shift register and the registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         tx       <= 1'b1;
         tx_ready <= 1'b1;
         tx_busy  <= 1'b0;
      end else begin
         state    <= state_nxt;
         shreg    <= shreg_nxt;
         bit_cnt  <= bit_cnt_nxt;
         stop_cnt <= stop_cnt_nxt;
         tx       <= tx_nxt;
         tx_ready <= ready_nxt;
         tx_busy  <= busy_nxt;
      end
   end

   // Next-state and next-output logic; every non-idle move waits for baud_tick.
   always_comb begin
      state_nxt    = state;
      shreg_nxt    = shreg;
      bit_cnt_nxt  = bit_cnt;
      stop_cnt_nxt = stop_cnt;
      tx_nxt       = tx;
      ready_nxt    = tx_ready;
      busy_nxt     = tx_busy;

      unique case (state)
         ST_IDLE: begin
            tx_nxt = 1'b1;
            if (tx_valid && tx_ready) begin
               shreg_nxt = tx_data;
               state_nxt = ST_SYNC;
               ready_nxt = 1'b0;
               busy_nxt  = 1'b1;
            end
         end

         ST_SYNC: begin
            if (baud_tick) begin
               state_nxt = ST_START;
               tx_nxt    = 1'b0;
            end
         end

         ST_START: begin
            if (baud_tick) begin
               state_nxt   = ST_DATA;
               tx_nxt      = shreg[0];
               shreg_nxt   = shreg_rot;
               bit_cnt_nxt = '0;
            end
         end

         ST_DATA: begin
            if (baud_tick) begin
               if (bit_cnt != LAST_BIT) begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
                  tx_nxt      = shreg[0];
                  shreg_nxt   = shreg_rot;
               end else if (PARITY_EN) begin
                  state_nxt = ST_PARITY;
                  tx_nxt    = parity;
               end else begin
                  state_nxt    = ST_STOP;
                  tx_nxt       = 1'b1;
                  stop_cnt_nxt = 1'b0;
               end
            end
         end

         ST_PARITY: begin
            if (baud_tick) begin
               state_nxt    = ST_STOP;
               tx_nxt       = 1'b1;
               stop_cnt_nxt = 1'b0;
            end
         end

         ST_STOP: begin
            if (baud_tick) begin
               if (stop_cnt != LAST_STOP) begin
                  stop_cnt_nxt = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
                  ready_nxt = 1'b1;
                  busy_nxt  = 1'b0;
                  tx_nxt    = 1'b1;
               end
            end
         end

         default: begin
            state_nxt = ST_IDLE;
            tx_nxt    = 1'b1;
            ready_nxt = 1'b1;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   // Ready is exactly "in IDLE" and busy is its complement.
   ready_is_idle: assert property (@(posedge clk) disable iff (!rst_n)
      tx_ready == (state == ST_IDLE));
   busy_not_ready: assert property (@(posedge clk) disable iff (!rst_n)
      tx_busy == !tx_ready);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: five parameterisations share clock, reset
// and baud strobe; frames are decoded from the line against a bit-list model.
module tb_uart_tx;

   localparam int NDUT = 5;
   localparam int P    = 20;   // clk cycles per bit period
   localparam int CD [NDUT] = '{8, 8, 8, 5, 8};   // DATA_BITS
   localparam int CP [NDUT] = '{0, 1, 1, 1, 0};   // PARITY_EN
   localparam int CO [NDUT] = '{0, 0, 1, 0, 0};   // PARITY_ODD
   localparam int CS [NDUT] = '{1, 1, 1, 2, 2};   // STOP_BITS

   logic       clk = 1'b0;
   logic       rst_n;
   logic       baud_tick;
   logic       tick_at_edge = 1'b0;
   logic       vld  [NDUT];
   logic [7:0] dat  [NDUT];
   logic       rdy  [NDUT];
   logic       tx_o [NDUT];
   logic       busy [NDUT];
   int         ph;
   int         total = 0;
   int         bad   = 0;

   always #5 clk = ~clk;

   uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(dat[0]),
      .tx_valid(vld[0]), .tx_ready(rdy[0]), .tx(tx_o[0]), .tx_busy(busy[0]));
   uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(dat[1]),
      .tx_valid(vld[1]), .tx_ready(rdy[1]), .tx(tx_o[1]), .tx_busy(busy[1]));
   uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(dat[2]),
      .tx_valid(vld[2]), .tx_ready(rdy[2]), .tx(tx_o[2]), .tx_busy(busy[2]));
   uart_tx #(.DATA_BITS(5), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(dat[3][4:0]),
      .tx_valid(vld[3]), .tx_ready(rdy[3]), .tx(tx_o[3]), .tx_busy(busy[3]));
   uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) dut4 (
      .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .tx_data(dat[4]),
      .tx_valid(vld[4]), .tx_ready(rdy[4]), .tx(tx_o[4]), .tx_busy(busy[4]));

   // Baud strobe: one edge in every P carries baud_tick=1; updated just after
   // each rising edge so it is stable around both edges.
   initial begin
      baud_tick = 1'b0;
      ph = 0;
      forever begin
         @(posedge clk);
         #2;
         ph = (ph == P - 1) ? 0 : ph + 1;
         baud_tick = (ph == P - 1);
      end
   end

   // Remember whether the most recent rising edge carried a tick.
   always @(posedge clk) tick_at_edge <= baud_tick;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference frame: start(0), data LSB first, parity from a ones count, stops(1).
   function automatic int frame_len(input int k);
      return 1 + CD[k] + CP[k] + CS[k];
   endfunction

   function automatic logic exp_bit(input int k, input logic [7:0] b, input int i);
      int ones;
      if (i == 0) return 1'b0;
      if (i <= CD[k]) return b[i-1];
      if (CP[k] != 0 && i == CD[k] + 1) begin
         ones = 0;
         for (int j = 0; j < CD[k]; j++) ones += int'(b[j]);
         return ((ones % 2) == 1) ^ (CO[k] != 0);
      end
      return 1'b1;
   endfunction

   task automatic send(input int k, input logic [7:0] b, input logic [7:0] post,
                       input bit on_tick);
      int n;
      @(negedge clk);
      n = 0;
      while (rdy[k] !== 1'b1 && n < 20 * P) begin @(negedge clk); n++; end
      chk($sformatf("k%0d_ready_wait", k), rdy[k], 1);
      if (on_tick) begin
         n = 0;
         while (baud_tick !== 1'b1 && n < P + 2) begin @(negedge clk); n++; end
         chk("tick_wait", baud_tick, 1);
      end
      vld[k] = 1'b1;
      dat[k] = b;
      @(negedge clk);
      chk($sformatf("k%0d_hs_ready_low", k), rdy[k], 0);
      chk($sformatf("k%0d_hs_busy_high", k), busy[k], 1);
      dat[k] = post;
      vld[k] = 1'b0;
   endtask

   // Entered at the first falling edge after the handshake edge.
   task automatic check_line(input int k, input logic [7:0] b, input bit exact,
                             output logic [15:0] seen);
      int n, len, bad_cyc, busy_bad;
      logic e;
      seen = '0;
      n = 0;
      while (tx_o[k] === 1'b1 && n < 2 * P + 4) begin @(negedge clk); n++; end
      chk($sformatf("k%0d_start_seen", k), tx_o[k], 0);
      if (tx_o[k] !== 1'b0) return;
      chk($sformatf("k%0d_start_on_tick", k), tick_at_edge, 1);
      if (exact) chk($sformatf("k%0d_sync_lat", k), n, P);
      else       chk($sformatf("k%0d_sync_lat_range", k), (n >= 1 && n <= P), 1);
      len = frame_len(k);
      bad_cyc = 0;
      busy_bad = 0;
      for (int i = 0; i < len; i++) begin
         e = exp_bit(k, b, i);
         for (int c = 0; c < P; c++) begin
            if (i != 0 || c != 0) @(negedge clk);
            if (c == P / 2) seen[i] = tx_o[k];
            if (tx_o[k] !== e) bad_cyc++;
            if (busy[k] !== 1'b1) busy_bad++;
         end
         chk($sformatf("k%0d_bit%0d", k, i), seen[i], e);
      end
      chk($sformatf("k%0d_bit_timing_errs", k), bad_cyc, 0);
      chk($sformatf("k%0d_busy_in_frame_errs", k), busy_bad, 0);
      @(negedge clk);
      chk($sformatf("k%0d_end_tx", k), tx_o[k], 1);
      chk($sformatf("k%0d_end_busy", k), busy[k], 0);
      chk($sformatf("k%0d_end_ready", k), rdy[k], 1);
   endtask

   task automatic idle_check(input int k, input int cycles);
      int errs;
      errs = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (tx_o[k] !== 1'b1 || busy[k] !== 1'b0) errs++;
      end
      chk($sformatf("k%0d_idle_errs", k), errs, 0);
   endtask

   typedef struct {
      int         k;
      logic [7:0] data;
      logic [7:0] post;      // tx_data value applied right after the handshake
      bit         on_tick;   // handshake edge coincides with baud_tick
      int         exp_par;   // expected parity bit on the line, -1 when none
   } vec_t;

   initial begin
      vec_t       vecs [8];
      logic [15:0] seen;
      int          k, gap;
      logic [7:0]  b;
      bit          ot;

      vecs[0] = '{k: 0, data: 8'h55, post: 8'hAA, on_tick: 0, exp_par: -1};
      vecs[1] = '{k: 1, data: 8'h07, post: 8'h00, on_tick: 0, exp_par: 1};
      vecs[2] = '{k: 2, data: 8'h07, post: 8'h00, on_tick: 0, exp_par: 0};
      vecs[3] = '{k: 0, data: 8'h00, post: 8'hFF, on_tick: 0, exp_par: -1};
      vecs[4] = '{k: 0, data: 8'hC3, post: 8'h3C, on_tick: 1, exp_par: -1};
      vecs[5] = '{k: 3, data: 8'h16, post: 8'h0F, on_tick: 1, exp_par: 1};
      vecs[6] = '{k: 2, data: 8'hFF, post: 8'h00, on_tick: 1, exp_par: 1};
      vecs[7] = '{k: 4, data: 8'h80, post: 8'h7F, on_tick: 0, exp_par: -1};

      rst_n = 1'b0;
      for (int i = 0; i < NDUT; i++) begin vld[i] = 1'b0; dat[i] = 8'h00; end
      repeat (3) @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
         chk($sformatf("k%0d_rst_tx", i), tx_o[i], 1);
         chk($sformatf("k%0d_rst_ready", i), rdy[i], 1);
         chk($sformatf("k%0d_rst_busy", i), busy[i], 0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 8; v++) begin
         send(vecs[v].k, vecs[v].data, vecs[v].post, vecs[v].on_tick);
         check_line(vecs[v].k, vecs[v].data, vecs[v].on_tick, seen);
         if (vecs[v].exp_par >= 0)
            chk($sformatf("vec%0d_parity", v), seen[1 + CD[vecs[v].k]], vecs[v].exp_par);
      end

      // Back-to-back with valid held through the stop bits.
      @(negedge clk);
      vld[4] = 1'b1;
      dat[4] = 8'hA5;
      @(negedge clk);
      chk("b2b_first_accept", rdy[4], 0);
      dat[4] = 8'h3C;
      check_line(4, 8'hA5, 1'b0, seen);
      @(negedge clk);
      chk("b2b_second_accept", rdy[4], 0);
      vld[4] = 1'b0;
      dat[4] = 8'h00;
      check_line(4, 8'h3C, 1'b0, seen);
      idle_check(4, 2 * P);

      // Reset in the middle of data bit 3.
      send(0, 8'h00, 8'h00, 1'b0);
      begin
         int n;
         n = 0;
         while (tx_o[0] === 1'b1 && n < 2 * P + 4) begin @(negedge clk); n++; end
         chk("rst_mid_start_seen", tx_o[0], 0);
      end
      repeat (4 * P + P / 2) @(negedge clk);
      chk("rst_mid_bit3_low", tx_o[0], 0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_tx", tx_o[0], 1);
      chk("rst_mid_ready", rdy[0], 1);
      chk("rst_mid_busy", busy[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_check(0, 3 * P);
      send(0, 8'h3C, 8'hC3, 1'b0);
      check_line(0, 8'h3C, 1'b0, seen);

      // Randomised frames across all configurations.
      for (int r = 0; r < 25; r++) begin
         k   = int'($urandom_range(0, NDUT - 1));
         b   = 8'($urandom);
         gap = int'($urandom_range(0, P));
         ot  = 1'($urandom_range(0, 1));
         repeat (gap) @(negedge clk);
         send(k, b, 8'($urandom), ot);
         check_line(k, b, ot, seen);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, 8, payload bits per frame; legal range 5..8.
REQ-002 Parameter PARITY_EN, 0, 1 inserts a parity bit after the data bits.
REQ-003 Parameter PARITY_ODD, 0, 1 selects odd parity, 0 selects even parity; ignored when PARITY_EN=0.
REQ-004 Parameter STOP_BITS, 1, stop bits per frame; legal values 1 and 2.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 baud_tick  input  1  one-clk-wide bit-period strobe from baud_rate_generator.
REQ-008 tx_data  input  DATA_BITS  byte to send; sampled only on handshake.
REQ-009 tx_valid  input  1  upstream has a byte on tx_data.
REQ-010 tx_ready  output  1  block accepts a byte this cycle; registered.
REQ-011 tx  output  1  serial line, idle high; registered.
REQ-012 tx_busy  output  1  high from handshake until end of last stop bit; registered.

Function
REQ-013 Handshake SHALL occur on a rising clk edge with tx_valid=1 and tx_ready=1; tx_data SHALL be latched into a shift register at that edge.
REQ-014 tx_ready SHALL be 1 only in IDLE; it SHALL drop to 0 the cycle after handshake; tx_busy SHALL rise in the same cycle.
REQ-015 States SHALL be IDLE, SYNC, START, DATA, PARITY, STOP; all transitions out of SYNC/START/DATA/PARITY/STOP SHALL happen only on a clk edge where baud_tick=1.
REQ-016 IDLE: tx=1; baud_tick ignored; handshake -> SYNC.
REQ-017 SYNC: tx=1; on baud_tick -> START with tx<=0, so the start bit begins on a tick boundary.
REQ-018 START: on baud_tick -> DATA with tx<=data bit 0 (LSB first), bit counter=0.
REQ-019 DATA: on baud_tick, if bit counter < DATA_BITS-1, counter increments and tx<=next bit; else -> PARITY (PARITY_EN=1) with tx<=parity bit, or -> STOP with tx<=1.
REQ-020 Parity bit SHALL be XOR of the DATA_BITS latched bits, inverted when PARITY_ODD=1.
REQ-021 PARITY: on baud_tick -> STOP with tx<=1, stop counter=0.
REQ-022 STOP: on baud_tick, if stop counter < STOP_BITS-1, counter increments; else -> IDLE, tx_ready<=1, tx_busy<=0, tx stays 1.
REQ-023 Each bit SHALL occupy exactly one baud_tick period on tx; frame length SHALL be 1+DATA_BITS+PARITY_EN+STOP_BITS tick periods, plus 0..1 period of SYNC latency.
REQ-024 Changes on tx_data or tx_valid after handshake SHALL NOT affect the frame in flight.
REQ-025 A byte held valid during STOP SHALL be accepted on the first cycle tx_ready=1 after return to IDLE; no bytes SHALL be dropped or duplicated.
REQ-026 baud_tick coinciding with the handshake edge SHALL NOT advance SYNC; the next tick does.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, tx=1, tx_ready=1, tx_busy=0, and counters and shift register to 0.
REQ-028 Reset mid-frame SHALL abort the frame; tx SHALL go high without waiting for a clk edge; the aborted byte SHALL NOT be retransmitted.

Structure
REQ-029 Package uart_pkg SHALL hold the state encoding enum and the DATA_BITS/STOP_BITS default constants, and SHALL be shared with a future uart_rx.
REQ-030 No sub-module SHALL be used; baud_rate_generator SHALL be instantiated beside uart_tx at the parent level and drive baud_tick.

Verification
REQ-031 Scenario: defaults, BAUD_RATE_NUMBER=20, send 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1 with 20 clk per bit, then idle high.
REQ-032 Scenario: PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0.
REQ-033 Scenario: STOP_BITS=2, back-to-back 0xA5 and 0x3C with tx_valid held -> two stop periods high, second start bit aligned to a tick, both bytes correct.
REQ-034 Scenario: change tx_data to 0xFF one cycle after accepting 0x00 -> eight 0 data bits on tx.
REQ-035 Scenario: rst_n low during data bit 3 of 0x00 -> tx=1 immediately, tx_ready=1, tx_busy=0; next byte sent correctly after release.
REQ-036 Scenario: handshake on the same edge as baud_tick -> start bit begins on the following tick, not the current one.
